mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_rr_arb2.sv | 18 +
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: port identities and lock FSM states.
package mem_arb_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: bit 0 is the instruction port, bit 1 the data port.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    // On conflict the port that did not win most recently goes first.
    if (req_i == 2'b11) begin
      gnt_o = (last_i == OWN_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction read port and a data read/write port onto one single-port SRAM,
// with a bounded data-port lock for read-modify-write sequences.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_bweb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [31:0]       sram_bweb,
  output logic [ADDR_W-3:0] sram_a,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do
);

  localparam int unsigned CntW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  state_e          state_q, state_d, state_eff;
  owner_e          last_q, last_d;
  owner_e          rsp_own_q, rsp_own_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      rr_gnt;
  logic            lock_done;
  logic            addr_lsb_unused;

  assign addr_lsb_unused = ^{i_addr[1:0], d_addr[1:0]};

  rr_arb2 u_rr_arb2 (
    .req_i  ({d_req, i_req}),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  assign lock_done = (cnt_q == CntW'(LOCK_MAX - 1));

  always_comb begin
    // While reset is asserted the grant logic behaves as if idle.
    state_eff = rst ? state_q : ST_IDLE;
    state_d   = state_eff;
    last_d    = last_q;
    cnt_d     = cnt_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    unique case (state_eff)
      ST_IDLE: begin
        i_gnt = rr_gnt[0];
        d_gnt = rr_gnt[1];
        if (d_gnt && d_lock) begin
          state_d = ST_LOCK;
          cnt_d   = '0;
        end
      end
      ST_LOCK: begin
        d_gnt = d_req;
        cnt_d = cnt_q + CntW'(1);
        if (lock_done || (d_gnt && !d_lock)) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    if (i_gnt) begin
      last_d = OWN_I;
    end else if (d_gnt) begin
      last_d = OWN_D;
    end
    // A forced release hands priority to the instruction port.
    if (state_eff == ST_LOCK && lock_done) begin
      last_d = OWN_D;
    end
    rsp_vld_d = i_gnt | (d_gnt & ~d_we);
    rsp_own_d = i_gnt ? OWN_I : OWN_D;
  end

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    if (i_gnt) begin
      sram_ceb = 1'b0;
      sram_a   = i_addr[ADDR_W-1:2];
    end else if (d_gnt) begin
      sram_ceb  = 1'b0;
      sram_web  = ~d_we;
      sram_bweb = d_we ? d_bweb : '1;
      sram_a    = d_addr[ADDR_W-1:2];
      sram_di   = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_q    <= OWN_D;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_own_q <= OWN_I;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_own_q <= rsp_own_d;
    end
  end

  assign i_rvalid = rsp_vld_q & (rsp_own_q == OWN_I);
  assign d_rvalid = rsp_vld_q & (rsp_own_q == OWN_D);
  assign i_rdata  = sram_do;
  assign d_rdata  = sram_do;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against
// a behavioural model of grants, lock windows and read responses.
module tb_mem_arbiter;

  localparam int LOCK_MAX = 8;
  localparam int ADDR_W   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic [31:0]       d_bweb = '1, d_wdata = '0, sram_do = '0;
  logic              i_gnt, i_rvalid, d_gnt, d_rvalid, sram_ceb, sram_web;
  logic [31:0]       i_rdata, d_rdata, sram_bweb, sram_di;
  logic [ADDR_W-3:0] sram_a;

  int total = 0;
  int bad   = 0;

  // Model: whether the data port holds the memory, how many locked cycles have elapsed,
  // who was granted last, and which response is due this cycle.
  bit m_lock, m_last_d, m_rsp_i, m_rsp_d;
  int m_held;

  mem_arbiter #(.LOCK_MAX(LOCK_MAX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_bweb(d_bweb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  function automatic void exp_gnt(output bit gi, output bit gd);
    if (m_lock) begin
      gi = 1'b0;
      gd = d_req;
    end else if (i_req && d_req) begin
      gi = m_last_d;
      gd = !m_last_d;
    end else begin
      gi = i_req;
      gd = d_req;
    end
  endfunction

  task automatic tick();
    bit gi, gd;
    @(posedge clk);
    if (!rst) begin
      m_lock = 0; m_held = 0; m_last_d = 1; m_rsp_i = 0; m_rsp_d = 0;
    end else begin
      exp_gnt(gi, gd);
      m_rsp_i = gi;
      m_rsp_d = gd && !d_we;
      if (gi) m_last_d = 0;
      if (gd) m_last_d = 1;
      if (m_lock) begin
        if (m_held == LOCK_MAX - 1) begin
          m_lock = 0;
          m_last_d = 1;
        end else if (gd && !d_lock) begin
          m_lock = 0;
        end else begin
          m_held++;
        end
      end else if (gd && d_lock) begin
        m_lock = 1;
        m_held = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    i_req = 0; d_req = 0; d_we = 0; d_lock = 0; d_bweb = '1; d_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b00) begin
      bad++; $display("FAIL reset_rvalid: got %b want 00", {i_rvalid, d_rvalid});
    end
    total++;
    if ({i_gnt, d_gnt} !== 2'b00) begin
      bad++; $display("FAIL reset_gnt: got %b want 00", {i_gnt, d_gnt});
    end
    total++;
    if ({sram_ceb, sram_web, sram_bweb, sram_a, sram_di} !== {2'b11, 32'hFFFFFFFF, 14'h0, 32'h0})
    begin
      bad++; $display("FAIL reset_sram: got ceb=%b web=%b bweb=%h a=%h di=%h want idle bus",
                      sram_ceb, sram_web, sram_bweb, sram_a, sram_di);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    i_req  = 1;
    i_addr = 16'h0010;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, sram_ceb, sram_web} !== 4'b1001) begin
      bad++; $display("FAIL read_gnt: got %b want 1001", {i_gnt, d_gnt, sram_ceb, sram_web});
    end
    total++;
    if (sram_a !== 14'h0004) begin
      bad++; $display("FAIL read_addr: got %h want 0004", sram_a);
    end
    tick();
    idle();
    sram_do = $urandom;
    @(negedge clk);
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b10) begin
      bad++; $display("FAIL read_rvalid: got %b want 10", {i_rvalid, d_rvalid});
    end
    total++;
    if (i_rdata !== sram_do) begin
      bad++; $display("FAIL read_rdata: got %h want %h", i_rdata, sram_do);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [1:0] eg[3] = '{2'b10, 2'b01, 2'b10};
    logic [1:0] er[3] = '{2'b00, 2'b10, 2'b01};
    do_reset();
    i_req = 1; d_req = 1; d_we = 0;
    i_addr = 16'h0020; d_addr = 16'h0040;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({i_gnt, d_gnt} !== eg[c]) begin
        bad++; $display("FAIL conflict_gnt[%0d]: got %b want %b", c, {i_gnt, d_gnt}, eg[c]);
      end
      total++;
      if ({i_rvalid, d_rvalid} !== er[c]) begin
        bad++; $display("FAIL conflict_rv[%0d]: got %b want %b", c, {i_rvalid, d_rvalid}, er[c]);
      end
      tick();
    end
    idle();
    @(negedge clk);
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b10) begin
      bad++; $display("FAIL conflict_rv_last: got %b want 10", {i_rvalid, d_rvalid});
    end
    tick();
  endtask

  task automatic test_write();
    do_reset();
    d_req = 1; d_we = 1; d_bweb = 32'hFFFF0000; d_addr = 16'h0100; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({d_gnt, sram_ceb, sram_web} !== 3'b100) begin
      bad++; $display("FAIL write_ctl: got %b want 100", {d_gnt, sram_ceb, sram_web});
    end
    total++;
    if ({sram_bweb, sram_a, sram_di} !== {32'hFFFF0000, 14'h0040, 32'hDEADBEEF}) begin
      bad++; $display("FAIL write_bus: got bweb=%h a=%h di=%h want ffff0000/0040/deadbeef",
                      sram_bweb, sram_a, sram_di);
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b00) begin
      bad++; $display("FAIL write_rvalid: got %b want 00", {i_rvalid, d_rvalid});
    end
    tick();
  endtask

  task automatic test_lock();
    logic [1:0] eg[4] = '{2'b01, 2'b00, 2'b01, 2'b10};
    do_reset();
    i_req = 1; i_addr = 16'h0008;
    tick();  // instruction wins first so the data port wins the next conflict
    for (int c = 0; c < 4; c++) begin
      d_req  = (c != 1) && (c != 3);
      d_lock = (c == 0);
      d_we   = (c == 2);
      @(negedge clk);
      total++;
      if ({i_gnt, d_gnt} !== eg[c]) begin
        bad++; $display("FAIL lock_gnt[%0d]: got %b want %b", c, {i_gnt, d_gnt}, eg[c]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    i_req = 1;
    tick();
    d_req = 1; d_lock = 1; d_we = 0;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      bad++; $display("FAIL timeout_entry: got %b want 01", {i_gnt, d_gnt});
    end
    tick();
    for (int k = 0; k < LOCK_MAX; k++) begin
      @(negedge clk);
      total++;
      if ({i_gnt, d_gnt} !== 2'b01) begin
        bad++; $display("FAIL timeout_held[%0d]: got %b want 01", k, {i_gnt, d_gnt});
      end
      tick();
    end
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      bad++; $display("FAIL timeout_release: got %b want 10", {i_gnt, d_gnt});
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    d_req = 1; d_lock = 1; d_we = 0;
    tick();
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      bad++; $display("FAIL midrst_gnt: got %b want 01", {i_gnt, d_gnt});
    end
    rst = 0;
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b00) begin
      bad++; $display("FAIL midrst_rvalid: got %b want 00", {i_rvalid, d_rvalid});
    end
    rst = 1;
    tick();
    i_req = 1; d_req = 1;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      bad++; $display("FAIL midrst_state: got %b want 10", {i_gnt, d_gnt});
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    bit gi, gd;
    logic [79:0] exp_bus;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 99) != 0);
      i_req   = rst && ($urandom_range(0, 9) < 6);
      d_req   = rst && ($urandom_range(0, 9) < 6);
      d_we    = ($urandom_range(0, 9) < 3);
      d_lock  = ((n / 40) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      d_bweb  = $urandom;
      d_wdata = $urandom;
      sram_do = $urandom;
      exp_gnt(gi, gd);
      exp_bus = {!(gi || gd), gd ? !d_we : 1'b1, (gd && d_we) ? d_bweb : 32'hFFFFFFFF,
                 gi ? 14'(i_addr >> 2) : gd ? 14'(d_addr >> 2) : 14'h0,
                 (!gi && gd) ? d_wdata : 32'h0};
      @(negedge clk);
      total++;
      if ({i_gnt, d_gnt} !== {gi, gd}) begin
        bad++; $display("FAIL rand_gnt[%0d]: got %b want %b", n, {i_gnt, d_gnt}, {gi, gd});
      end
      total++;
      if ({sram_ceb, sram_web, sram_bweb, sram_a, sram_di} !== exp_bus) begin
        bad++; $display("FAIL rand_sram[%0d]: got %h want %h", n,
                        {sram_ceb, sram_web, sram_bweb, sram_a, sram_di}, exp_bus);
      end
      total++;
      if ({i_rvalid, d_rvalid} !== {m_rsp_i, m_rsp_d}) begin
        bad++; $display("FAIL rand_rvalid[%0d]: got %b want %b", n, {i_rvalid, d_rvalid},
                        {m_rsp_i, m_rsp_d});
      end
      if (m_rsp_i || m_rsp_d) begin
        total++;
        if ((m_rsp_i ? i_rdata : d_rdata) !== sram_do) begin
          bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", n,
                          m_rsp_i ? i_rdata : d_rdata, sram_do);
        end
      end
      tick();
    end
    idle();
    rst = 1;
  endtask

  initial begin
    m_lock = 0; m_held = 0; m_last_d = 1; m_rsp_i = 0; m_rsp_d = 0;
    test_reset();
    test_single_read();
    test_conflict();
    test_write();
    test_lock();
    test_lock_timeout();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
